// File: rtl/bus_pkg.sv
// Shared types for the two-channel memory bus arbiter: request payload,
// arbiter states, channel identifiers and transfer-mode encodings.
package bus_pkg;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_t;

    typedef enum logic {CH_FETCH, CH_MEM} ch_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/bus_arbiter_req_slot.sv
// One-entry pending request holder for a single channel; a load onto an
// occupied slot is dropped and reported as an overflow.
module req_slot
    import bus_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_load,
    input  bus_req_t i_req,
    input  logic     i_clear,
    output logic     o_pending,
    output bus_req_t o_req,
    output logic     o_overflow
);

    logic     r_pending;
    bus_req_t r_req;

    // A load arriving on the clearing edge still sees the slot occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_req     <= '0;
        end else if (i_load && !r_pending) begin
            r_pending <= 1'b1;
            r_req     <= i_req;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end
    end

    assign o_pending  = r_pending;
    assign o_req      = r_req;
    assign o_overflow = i_load && r_pending;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between fetch and data-memory channels onto one
// external valid/ready bus; routes each response back to its owner.
module bus_arbiter
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        f_req_enable,
    input  logic        f_mode,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_wdata,
    input  logic [3:0]  f_wstrb,
    output logic        f_resp_enable,
    output logic [31:0] f_resp_data,
    input  logic        m_req_enable,
    input  logic        m_mode,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    output logic        m_resp_enable,
    output logic [31:0] m_resp_data,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_mode,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_data,
    output logic        protocol_error
);

    arb_state_t r_state, w_state_nx;
    ch_t        r_owner, r_last_grant, w_grant_ch;
    bus_req_t   r_bus_req, w_f_req, w_m_req;
    logic       r_bus_req_valid;
    logic       r_f_resp_enable, r_m_resp_enable;
    logic [31:0] r_f_resp_data, r_m_resp_data;
    logic       r_err;
    logic       w_f_pend, w_m_pend, w_f_ovf, w_m_ovf;
    logic       w_grant, w_accept, w_resp, w_stray;
    logic       w_f_clear, w_m_clear;

    assign w_f_clear = w_accept && (r_owner == CH_FETCH);
    assign w_m_clear = w_accept && (r_owner == CH_MEM);

    req_slot u_f_slot (
        .clk        (clk),
        .rst        (rst),
        .i_load     (f_req_enable),
        .i_req      ('{mode: f_mode, addr: f_addr, wdata: f_wdata, wstrb: f_wstrb}),
        .i_clear    (w_f_clear),
        .o_pending  (w_f_pend),
        .o_req      (w_f_req),
        .o_overflow (w_f_ovf)
    );

    req_slot u_m_slot (
        .clk        (clk),
        .rst        (rst),
        .i_load     (m_req_enable),
        .i_req      ('{mode: m_mode, addr: m_addr, wdata: m_wdata, wstrb: m_wstrb}),
        .i_clear    (w_m_clear),
        .o_pending  (w_m_pend),
        .o_req      (w_m_req),
        .o_overflow (w_m_ovf)
    );

    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_grant_ch = CH_FETCH;
        w_accept   = 1'b0;
        w_resp     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_f_pend || w_m_pend) begin
                    w_grant    = 1'b1;
                    w_state_nx = ARB_REQ;
                    // On a tie the channel that did not win last time goes next.
                    if (w_f_pend && w_m_pend)
                        w_grant_ch = (r_last_grant == CH_FETCH) ? CH_MEM : CH_FETCH;
                    else
                        w_grant_ch = w_f_pend ? CH_FETCH : CH_MEM;
                end
            end
            ARB_REQ: begin
                if (bus_req_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (bus_resp_valid) begin
                    w_resp     = 1'b1;
                    w_state_nx = ARB_IDLE;
                end
            end
            default: w_state_nx = ARB_IDLE;
        endcase
    end

    assign w_stray = bus_resp_valid && (r_state != ARB_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ARB_IDLE;
            r_owner         <= CH_FETCH;
            r_last_grant    <= CH_MEM;
            r_bus_req       <= '0;
            r_bus_req_valid <= 1'b0;
            r_f_resp_enable <= 1'b0;
            r_m_resp_enable <= 1'b0;
            r_f_resp_data   <= '0;
            r_m_resp_data   <= '0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_f_resp_enable <= w_resp && (r_owner == CH_FETCH);
            r_m_resp_enable <= w_resp && (r_owner == CH_MEM);
            r_err           <= r_err || w_f_ovf || w_m_ovf || w_stray;
            if (w_grant) begin
                r_owner         <= w_grant_ch;
                r_last_grant    <= w_grant_ch;
                r_bus_req       <= (w_grant_ch == CH_FETCH) ? w_f_req : w_m_req;
                r_bus_req_valid <= 1'b1;
            end else if (w_accept) begin
                r_bus_req_valid <= 1'b0;
            end
            if (w_resp && (r_owner == CH_FETCH)) r_f_resp_data <= bus_resp_data;
            if (w_resp && (r_owner == CH_MEM))   r_m_resp_data <= bus_resp_data;
        end
    end

    assign bus_req_valid  = r_bus_req_valid;
    assign bus_mode       = r_bus_req.mode;
    assign bus_addr       = r_bus_req.addr;
    assign bus_wdata      = r_bus_req.wdata;
    assign bus_wstrb      = r_bus_req.wstrb;
    assign f_resp_enable  = r_f_resp_enable;
    assign f_resp_data    = r_f_resp_data;
    assign m_resp_enable  = r_m_resp_enable;
    assign m_resp_data    = r_m_resp_data;
    assign protocol_error = r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: the bench plays the external memory port
// cycle by cycle and checks every output against hand-derived values.
module tb_bus_arbiter;
    import bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req_enable, f_mode;
    logic [31:0] f_addr, f_wdata;
    logic [3:0]  f_wstrb;
    logic        f_resp_enable;
    logic [31:0] f_resp_data;
    logic        m_req_enable, m_mode;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_resp_enable;
    logic [31:0] m_resp_data;
    logic        bus_req_valid, bus_req_ready, bus_mode;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_data;
    logic        protocol_error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req_enable(f_req_enable), .f_mode(f_mode), .f_addr(f_addr),
        .f_wdata(f_wdata), .f_wstrb(f_wstrb),
        .f_resp_enable(f_resp_enable), .f_resp_data(f_resp_data),
        .m_req_enable(m_req_enable), .m_mode(m_mode), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_resp_enable(m_resp_enable), .m_resp_data(m_resp_data),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_mode(bus_mode), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_resp_valid(bus_resp_valid),
        .bus_resp_data(bus_resp_data), .protocol_error(protocol_error)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic        is_f;
        logic [31:0] exp_addr;

        rst = 1'b1;
        f_req_enable = 0; f_mode = 0; f_addr = 0; f_wdata = 0; f_wstrb = 0;
        m_req_enable = 0; m_mode = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
        bus_req_ready = 1'b1; bus_resp_valid = 0; bus_resp_data = 0;
        do_reset();

        check("rst_valid", bus_req_valid, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_fresp", f_resp_enable, 0);
        check("rst_mresp", m_resp_enable, 0);
        check("rst_err", protocol_error, 0);

        // Single fetch read, zero-wait ready, one-cycle response
        f_req_enable = 1; f_mode = MODE_READ; f_addr = 32'h0;
        step();
        f_req_enable = 0;
        check("t1_not_yet_valid", bus_req_valid, 0);
        step();
        check("t1_valid", bus_req_valid, 1);
        check("t1_addr", bus_addr, 32'h0);
        check("t1_mode", bus_mode, MODE_READ);
        step();
        check("t1_valid_drop", bus_req_valid, 0);
        bus_resp_valid = 1; bus_resp_data = 32'h0000_0013;
        step();
        bus_resp_valid = 0;
        check("t1_fresp", f_resp_enable, 1);
        check("t1_fdata", f_resp_data, 32'h0000_0013);
        check("t1_mresp", m_resp_enable, 0);
        step();
        check("t1_fresp_once", f_resp_enable, 0);

        // Simultaneous fetch read and mem write right after reset
        do_reset();
        f_req_enable = 1; f_mode = MODE_READ; f_addr = 32'h100;
        m_req_enable = 1; m_mode = MODE_WRITE; m_addr = 32'h2000;
        m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF;
        step();
        f_req_enable = 0; m_req_enable = 0;
        step();
        check("t2_f_valid", bus_req_valid, 1);
        check("t2_f_addr", bus_addr, 32'h100);
        check("t2_f_mode", bus_mode, MODE_READ);
        step();
        bus_resp_valid = 1; bus_resp_data = 32'hAAAA_0001;
        step();
        bus_resp_valid = 0;
        check("t2_fresp", f_resp_enable, 1);
        check("t2_fdata", f_resp_data, 32'hAAAA_0001);
        check("t2_no_mresp", m_resp_enable, 0);
        check("t2_idle_gap", bus_req_valid, 0);
        step();
        check("t2_m_valid", bus_req_valid, 1);
        check("t2_m_addr", bus_addr, 32'h2000);
        check("t2_m_mode", bus_mode, MODE_WRITE);
        check("t2_m_wdata", bus_wdata, 32'hDEAD_BEEF);
        check("t2_m_wstrb", bus_wstrb, 4'hF);
        check("t2_fresp_once", f_resp_enable, 0);
        step();
        bus_resp_valid = 1; bus_resp_data = 32'hBBBB_0002;
        step();
        bus_resp_valid = 0;
        check("t2_mresp", m_resp_enable, 1);
        check("t2_mdata", m_resp_data, 32'hBBBB_0002);
        check("t2_no_fresp", f_resp_enable, 0);
        step();
        check("t2_mresp_once", m_resp_enable, 0);

        // Ready held low for 5 cycles of valid
        bus_req_ready = 0;
        f_req_enable = 1; f_addr = 32'h300; f_wdata = 32'h1234_5678; f_wstrb = 4'h3;
        step();
        f_req_enable = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", bus_req_valid, 1);
            check("t3_hold_addr", bus_addr, 32'h300);
            check("t3_hold_wdata", bus_wdata, 32'h1234_5678);
            check("t3_hold_wstrb", bus_wstrb, 4'h3);
            step();
        end
        check("t3_valid_c6", bus_req_valid, 1);
        bus_req_ready = 1;
        step();
        check("t3_accepted", bus_req_valid, 0);
        bus_resp_valid = 1; bus_resp_data = 32'h0000_0333;
        step();
        bus_resp_valid = 0;
        check("t3_fresp", f_resp_enable, 1);
        check("t3_fdata", f_resp_data, 32'h0000_0333);
        step();

        // Second mem pulse while its slot is still pending
        bus_req_ready = 0;
        m_req_enable = 1; m_mode = MODE_READ; m_addr = 32'h400;
        step();
        m_req_enable = 0;
        check("t4_err_clean", protocol_error, 0);
        step();
        m_req_enable = 1; m_addr = 32'h500;
        step();
        m_req_enable = 0;
        check("t4_err_set", protocol_error, 1);
        check("t4_addr_kept", bus_addr, 32'h400);
        bus_req_ready = 1;
        step();
        check("t4_err_sticky", protocol_error, 1);
        bus_resp_valid = 1; bus_resp_data = 32'h0000_0044;
        step();
        bus_resp_valid = 0;
        check("t4_mresp", m_resp_enable, 1);
        check("t4_mdata", m_resp_data, 32'h0000_0044);
        step();
        step();
        check("t4_no_second_txn", bus_req_valid, 0);
        check("t4_err_still", protocol_error, 1);

        // Reset during WAIT, then a stray response
        do_reset();
        check("t5_err_cleared", protocol_error, 0);
        f_req_enable = 1; f_mode = MODE_WRITE; f_addr = 32'h600; f_wdata = 32'h6;
        step();
        f_req_enable = 0;
        step();
        check("t5_valid", bus_req_valid, 1);
        step();
        rst = 1;
        step();
        rst = 0;
        check("t5_valid0", bus_req_valid, 0);
        check("t5_addr0", bus_addr, 0);
        check("t5_mode0", bus_mode, 0);
        check("t5_wdata0", bus_wdata, 0);
        check("t5_fresp0", f_resp_enable, 0);
        check("t5_err0", protocol_error, 0);
        bus_resp_valid = 1; bus_resp_data = 32'h0000_0666;
        step();
        bus_resp_valid = 0;
        check("t5_no_fresp", f_resp_enable, 0);
        check("t5_no_mresp", m_resp_enable, 0);
        check("t5_stray_err", protocol_error, 1);
        step();
        check("t5_no_fresp_late", f_resp_enable, 0);

        // 20 back-to-back transactions with both channels kept busy
        do_reset();
        f_req_enable = 1; f_mode = MODE_READ;  f_addr = 32'h1000;
        m_req_enable = 1; m_mode = MODE_WRITE; m_addr = 32'h8000;
        step();
        f_req_enable = 0; m_req_enable = 0;
        step();
        for (int t = 0; t < 20; t++) begin
            is_f     = (t % 2 == 0);
            exp_addr = (is_f ? 32'h1000 : 32'h8000) + 32'(t / 2) * 4;
            check("t6_valid", bus_req_valid, 1);
            check("t6_addr", bus_addr, exp_addr);
            step();
            check("t6_accept", bus_req_valid, 0);
            // Re-arm the owner's now-cleared slot during its own WAIT
            if (is_f) begin
                f_req_enable = 1; f_addr = 32'h1000 + 32'(t / 2 + 1) * 4;
            end else begin
                m_req_enable = 1; m_addr = 32'h8000 + 32'(t / 2 + 1) * 4;
            end
            bus_resp_valid = 1; bus_resp_data = 32'hC0DE_0000 + 32'(t);
            step();
            f_req_enable = 0; m_req_enable = 0; bus_resp_valid = 0;
            check("t6_fresp", f_resp_enable, is_f);
            check("t6_mresp", m_resp_enable, !is_f);
            check("t6_data", is_f ? f_resp_data : m_resp_data, 32'hC0DE_0000 + 32'(t));
            step();
        end
        check("t6_no_err", protocol_error, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
